// File: rtl/reset_request_controller_pkg.sv
// Shared types and helpers for the run-time reset sequencer.
// Holds the sequencer state encoding, default stagger/hold lengths and
// width helpers used by the top level and the request arbiter.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ASSERT_PROC = 3'd1,
    ASSERT_PERI = 3'd2,
    HOLD        = 3'd3,
    WAIT_LOCK   = 3'd4,
    REL_ICN     = 3'd5,
    REL_PERI    = 3'd6,
    ACK         = 3'd7
  } rst_seq_state_t;

  localparam int RST_SEQ_STAGGER_DEFAULT = 32;
  localparam int RST_SEQ_HOLD_DEFAULT    = 128;

  // Counter width able to hold max(a, b).
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

  // Index width for n requesters, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reset_request_controller_prio_arb.sv
// prio_arb: combinational fixed-priority encoder, index 0 highest priority.
// Ports: req (request vector), vld (any request set), idx (lowest set index).
// No state; the caller registers the index it decides to keep.
module prio_arb
  import rst_seq_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  output logic               vld,
  output logic [IDX_W-1:0]   idx
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    vld = 1'b0;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        vld = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/reset_request_controller.sv
// reset_request_controller: sequences interconnect/peripheral/processor resets.
// Ports: clk, async_reset (active-high), pll_locked, req/ack (four-phase per
// requester), busy, and the three active-high domain reset buses.
// Optional macro RST_CAUSE_LOG_EN adds last_cause and reset_count outputs.
module reset_request_controller
  import rst_seq_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int STAGGER_CYCLES = RST_SEQ_STAGGER_DEFAULT,
  parameter int HOLD_CYCLES    = RST_SEQ_HOLD_DEFAULT,
  parameter int NO_INTERCNCT   = 1,
  parameter int NO_PERIFERAL   = 1,
  parameter int NO_PROCESSOR   = 1
) (
  input  logic                    clk,
  input  logic                    async_reset,
  input  logic                    pll_locked,
  input  logic [NUM_REQ-1:0]      req,
  output logic [NUM_REQ-1:0]      ack,
  output logic                    busy,
  output logic [NO_INTERCNCT-1:0] intercnct_reset,
  output logic [NO_PERIFERAL-1:0] periferal_reset,
  output logic [NO_PROCESSOR-1:0] processor_reset
`ifdef RST_CAUSE_LOG_EN
  ,
  output logic [idx_width(NUM_REQ)-1:0] last_cause,
  output logic [7:0]                    reset_count
`endif
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CW    = cnt_width(STAGGER_CYCLES, HOLD_CYCLES);
  localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  rst_seq_state_t     state_q, state_nxt;
  logic [CW-1:0]      cnt_q, cnt_nxt;
  logic [IDX_W-1:0]   grant_q, grant_nxt;
  logic               grant_valid_q, grant_valid_nxt;
  logic               icn_q, icn_nxt;
  logic               peri_q, peri_nxt;
  logic               proc_q, proc_nxt;
  logic [NUM_REQ-1:0] ack_q, ack_nxt;
  logic               busy_q, busy_nxt;
  logic               lock_lost;

  logic               arb_vld;
  logic [IDX_W-1:0]   arb_idx;

  prio_arb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_prio_arb (
    .req (req),
    .vld (arb_vld),
    .idx (arb_idx)
  );

  // Reset lands in HOLD with everything asserted, so the power-on release
  // is just the tail of an ordinary sequence without a grant.
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      state_q       <= HOLD;
      cnt_q         <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      icn_q         <= 1'b1;
      peri_q        <= 1'b1;
      proc_q        <= 1'b1;
      ack_q         <= '0;
      busy_q        <= 1'b1;
    end else begin
      state_q       <= state_nxt;
      cnt_q         <= cnt_nxt;
      grant_q       <= grant_nxt;
      grant_valid_q <= grant_valid_nxt;
      icn_q         <= icn_nxt;
      peri_q        <= peri_nxt;
      proc_q        <= proc_nxt;
      ack_q         <= ack_nxt;
      busy_q        <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt       = state_q;
    cnt_nxt         = cnt_q;
    grant_nxt       = grant_q;
    grant_valid_nxt = grant_valid_q;
    icn_nxt         = icn_q;
    peri_nxt        = peri_q;
    proc_nxt        = proc_q;
    ack_nxt         = ack_q;
    lock_lost       = 1'b0;

    case (state_q)
      IDLE: begin
        // Lock loss wins over a new request; the request is a level and
        // will be picked up once the controller is back in IDLE.
        if (!pll_locked) begin
          lock_lost = 1'b1;
        end else if (arb_vld) begin
          grant_nxt       = arb_idx;
          grant_valid_nxt = 1'b1;
          proc_nxt        = 1'b1;
          cnt_nxt         = '0;
          state_nxt       = ASSERT_PROC;
        end
      end
      ASSERT_PROC: begin
        if (cnt_q == STAG_LAST) begin
          cnt_nxt   = '0;
          peri_nxt  = 1'b1;
          state_nxt = ASSERT_PERI;
        end else begin
          cnt_nxt = cnt_q + CW'(1);
        end
      end
      ASSERT_PERI: begin
        if (cnt_q == STAG_LAST) begin
          cnt_nxt   = '0;
          icn_nxt   = 1'b1;
          state_nxt = HOLD;
        end else begin
          cnt_nxt = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_nxt   = '0;
          state_nxt = WAIT_LOCK;
        end else begin
          cnt_nxt = cnt_q + CW'(1);
        end
      end
      WAIT_LOCK: begin
        if (pll_locked) begin
          cnt_nxt   = '0;
          icn_nxt   = 1'b0;
          state_nxt = REL_ICN;
        end
      end
      REL_ICN: begin
        if (!pll_locked) begin
          lock_lost = 1'b1;
        end else if (cnt_q == STAG_LAST) begin
          cnt_nxt   = '0;
          peri_nxt  = 1'b0;
          state_nxt = REL_PERI;
        end else begin
          cnt_nxt = cnt_q + CW'(1);
        end
      end
      REL_PERI: begin
        if (!pll_locked) begin
          lock_lost = 1'b1;
        end else if (cnt_q == STAG_LAST) begin
          cnt_nxt  = '0;
          proc_nxt = 1'b0;
          if (grant_valid_q) begin
            ack_nxt          = '0;
            ack_nxt[grant_q] = 1'b1;
            state_nxt        = ACK;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt_q + CW'(1);
        end
      end
      ACK: begin
        if (!pll_locked) begin
          lock_lost = 1'b1;
        end else if (!req[grant_q]) begin
          ack_nxt         = '0;
          grant_valid_nxt = 1'b0;
          state_nxt       = IDLE;
        end
      end
      default: begin
        lock_lost = 1'b1;
      end
    endcase

    // Lock loss re-enters HOLD with everything asserted; the grant is kept
    // so the original requester is still acknowledged after recovery.
    if (lock_lost) begin
      icn_nxt   = 1'b1;
      peri_nxt  = 1'b1;
      proc_nxt  = 1'b1;
      ack_nxt   = '0;
      cnt_nxt   = '0;
      state_nxt = HOLD;
    end

    busy_nxt = (state_nxt != IDLE);
  end

  assign ack             = ack_q;
  assign busy            = busy_q;
  assign intercnct_reset = {NO_INTERCNCT{icn_q}};
  assign periferal_reset = {NO_PERIFERAL{peri_q}};
  assign processor_reset = {NO_PROCESSOR{proc_q}};

`ifdef RST_CAUSE_LOG_EN
  // Power-on release never passes through IDLE, so it leaves the log alone.
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      last_cause  <= '0;
      reset_count <= '0;
    end else if (state_q == IDLE && state_nxt != IDLE) begin
      last_cause <= grant_nxt;
      if (reset_count != 8'hFF) begin
        reset_count <= reset_count + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_reset_request_controller.sv
module tb_reset_request_controller;

  localparam int S = 4;
  localparam int H = 8;
  localparam int SIG_BUSY = 0;
  localparam int SIG_PROC = 1;
  localparam int SIG_PERI = 2;
  localparam int SIG_ICN  = 3;
  localparam int SIG_ACK  = 4;

  logic       clk;
  logic       async_reset;
  logic       pll_locked;
  logic [3:0] req;
  logic [3:0] ack;
  logic       busy;
  logic [0:0] intercnct_reset;
  logic [0:0] periferal_reset;
  logic [0:0] processor_reset;
`ifdef RST_CAUSE_LOG_EN
  logic [1:0] last_cause;
  logic [7:0] reset_count;
`endif

  reset_request_controller #(
    .NUM_REQ        (4),
    .STAGGER_CYCLES (S),
    .HOLD_CYCLES    (H),
    .NO_INTERCNCT   (1),
    .NO_PERIFERAL   (1),
    .NO_PROCESSOR   (1)
  ) dut (
    .clk             (clk),
    .async_reset     (async_reset),
    .pll_locked      (pll_locked),
    .req             (req),
    .ack             (ack),
    .busy            (busy),
    .intercnct_reset (intercnct_reset),
    .periferal_reset (periferal_reset),
    .processor_reset (processor_reset)
`ifdef RST_CAUSE_LOG_EN
    ,
    .last_cause      (last_cause),
    .reset_count     (reset_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected output changes: cycle (posedge number), signal, new value.
  typedef struct {
    int cyc;
    int sig;
    int val;
  } ev_t;
  ev_t exp_q[$];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  bit done   = 1'b0;
  int cur[5];
  int prev[5];

  function automatic void ex(input int c, input int s, input int v);
    ev_t e;
    e.cyc = c;
    e.sig = s;
    e.val = v;
    exp_q.push_back(e);
  endfunction

  function automatic string sname(input int s);
    case (s)
      SIG_BUSY: return "busy";
      SIG_PROC: return "processor_reset";
      SIG_PERI: return "periferal_reset";
      SIG_ICN:  return "intercnct_reset";
      default:  return "ack";
    endcase
  endfunction

  // Assertion edges of a sequence starting at E0 (busy rises with it).
  function automatic void push_assert_chain(input int e0);
    ex(e0, SIG_BUSY, 1);
    ex(e0, SIG_PROC, 1);
    ex(e0 + S, SIG_PERI, 1);
    ex(e0 + 2 * S, SIG_ICN, 1);
  endfunction

  // Release edges starting with intercnct at cycle r; g < 0 means no grant.
  function automatic void push_release(input int r, input int g);
    ex(r, SIG_ICN, 0);
    ex(r + S, SIG_PERI, 0);
    if (g >= 0) begin
      ex(r + 2 * S, SIG_PROC, 0);
      ex(r + 2 * S, SIG_ACK, 1 << g);
    end else begin
      ex(r + 2 * S, SIG_BUSY, 0);
      ex(r + 2 * S, SIG_PROC, 0);
    end
  endfunction

  // Requester dropped its req right after edge a.
  function automatic void push_finish(input int a);
    ex(a + 1, SIG_BUSY, 0);
    ex(a + 1, SIG_ACK, 0);
  endfunction

  function automatic int lowest(input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) return i;
    return -1;
  endfunction

  // Return just after posedge number c (inputs driven here).
  task automatic wait_cyc(input int c);
    repeat (c - cyc) @(posedge clk);
    #1;
  endtask

  // Raise a set of requests together, optionally one more while busy; serve
  // them by index order among whatever is pending at each arbitration.
  task automatic do_round(input logic [3:0] mask, input int late);
    logic [3:0] pend;
    int e0, g, ak, d;
    bit first;
    first = 1'b1;
    pend  = mask;
    req   = req | mask;
    e0    = cyc + 1;
    while (pend != 4'd0) begin
      g = lowest(pend);
      push_assert_chain(e0);
      push_release(e0 + 2 * S + H + 1, g);
      ak = e0 + 4 * S + H + 1;
      if (first && late >= 0) begin
        wait_cyc(e0 + 3);
        req[late]  = 1'b1;
        pend[late] = 1'b1;
      end
      first = 1'b0;
      d = int'($urandom_range(0, 4));
      wait_cyc(ak + d);
      req[g]  = 1'b0;
      pend[g] = 1'b0;
      push_finish(ak + d);
      e0 = ak + d + 2;
    end
    wait_cyc(e0 + int'($urandom_range(0, 3)));
  endtask

  // pll_locked low from inside HOLD for `gap` cycles.
  task automatic hold_lock_gap(input int gap);
    int g, e0, p, ak, d;
    g = int'($urandom_range(0, 3));
    req[g] = 1'b1;
    e0 = cyc + 1;
    push_assert_chain(e0);
    wait_cyc(e0 + 2 * S + 2);
    pll_locked = 1'b0;
    p = cyc;
    wait_cyc(p + gap);
    pll_locked = 1'b1;
    push_release(p + gap + 1, g);
    ak = p + gap + 1 + 2 * S;
    d = int'($urandom_range(0, 4));
    wait_cyc(ak + d);
    req[g] = 1'b0;
    push_finish(ak + d);
    wait_cyc(ak + d + 3);
  endtask

  // One-cycle lock loss seen at edge r+j+1, where r is the intercnct release.
  task automatic lock_rerun(input int j);
    int g, e0, r, l, ak, d;
    g = int'($urandom_range(0, 3));
    req[g] = 1'b1;
    e0 = cyc + 1;
    push_assert_chain(e0);
    r = e0 + 2 * S + H + 1;
    l = r + j + 1;
    ex(r, SIG_ICN, 0);
    if (l > r + S) ex(r + S, SIG_PERI, 0);
    if (l > r + S) ex(l, SIG_PERI, 1);
    ex(l, SIG_ICN, 1);
    wait_cyc(l - 1);
    pll_locked = 1'b0;
    wait_cyc(l);
    pll_locked = 1'b1;
    push_release(l + H + 1, g);
    ak = l + H + 1 + 2 * S;
    d = int'($urandom_range(0, 4));
    wait_cyc(ak + d);
    req[g] = 1'b0;
    push_finish(ak + d);
    wait_cyc(ak + d + 3);
  endtask

  initial begin
    int c, l, e0, g, dd;
    req         = 4'd0;
    pll_locked  = 1'b1;
    async_reset = 1'b0;
    #1 async_reset = 1'b1;

    // Power-on: three cycles of reset, then the release tail.
    wait_cyc(3);
    mon_en = 1'b1;
    async_reset = 1'b0;
    push_release(cyc + H + 1, -1);
    wait_cyc(3 + H + 1 + 2 * S + 1);

    // Single requester, then two simultaneous requesters.
    do_round(4'b0100, -1);
    do_round(4'b1010, -1);

    // Randomised rounds, some with a request raised mid-sequence.
    for (int r = 0; r < 6; r++) begin
      logic [3:0] m;
      int late;
      m = 4'($urandom_range(1, 15));
      late = int'($urandom_range(0, 3));
      if (m[late] || ($urandom_range(0, 1) == 0)) late = -1;
      do_round(m, late);
    end

    hold_lock_gap(20);
    lock_rerun(S + int'($urandom_range(0, S - 1)));
    lock_rerun(int'($urandom_range(0, 2 * S - 1)));
    lock_rerun(int'($urandom_range(0, 2 * S - 1)));

    // Lock loss while idle: full reassert, release without any ack.
    c = cyc;
    pll_locked = 1'b0;
    l = c + 1;
    ex(l, SIG_BUSY, 1);
    ex(l, SIG_PROC, 1);
    ex(l, SIG_PERI, 1);
    ex(l, SIG_ICN, 1);
    wait_cyc(l);
    pll_locked = 1'b1;
    push_release(l + H + 1, -1);
    wait_cyc(l + H + 1 + 2 * S + 2);

    // Async reset in ASSERT_PERI: grant discarded, power-on tail reruns.
    g = int'($urandom_range(0, 3));
    req[g] = 1'b1;
    e0 = cyc + 1;
    push_assert_chain(e0);
    exp_q.pop_back();                // intercnct rises early, from the reset
    wait_cyc(e0 + S + 1);
    ex(cyc, SIG_ICN, 1);
    async_reset = 1'b1;
    req[g] = 1'b0;
    wait_cyc(e0 + S + 3);
    async_reset = 1'b0;
    dd = cyc;
    push_release(dd + H + 1, -1);
    wait_cyc(dd + H + 1 + 2 * S + 3);

    done = 1'b1;
  end

  // Monitor: samples on the falling edge, pops the expectation for every
  // output change, checks reset values and the domain ordering invariant.
  always @(negedge clk) begin
    cur[SIG_BUSY] = int'(busy);
    cur[SIG_PROC] = int'(processor_reset[0]);
    cur[SIG_PERI] = int'(periferal_reset[0]);
    cur[SIG_ICN]  = int'(intercnct_reset[0]);
    cur[SIG_ACK]  = int'({28'd0, ack});
    if (async_reset) begin
      checks++;
      if (cur[SIG_BUSY] != 1 || cur[SIG_PROC] != 1 || cur[SIG_PERI] != 1 ||
          cur[SIG_ICN] != 1 || cur[SIG_ACK] != 0) begin
        errors++;
        $display("FAIL reset_values cyc=%0d busy=%0d proc=%0d peri=%0d icn=%0d ack=%0d, required 1 1 1 1 0",
                 cyc, cur[SIG_BUSY], cur[SIG_PROC], cur[SIG_PERI], cur[SIG_ICN], cur[SIG_ACK]);
      end
`ifdef RST_CAUSE_LOG_EN
      checks++;
      if (reset_count != 8'd0) begin
        errors++;
        $display("FAIL reset_count_clear cyc=%0d got %0d, required 0", cyc, reset_count);
      end
`endif
    end
    if (mon_en) begin
      checks++;
      if ((cur[SIG_PROC] == 0 && (cur[SIG_PERI] != 0 || cur[SIG_ICN] != 0)) ||
          (cur[SIG_PERI] == 0 && cur[SIG_ICN] != 0)) begin
        errors++;
        $display("FAIL order_invariant cyc=%0d proc=%0d peri=%0d icn=%0d",
                 cyc, cur[SIG_PROC], cur[SIG_PERI], cur[SIG_ICN]);
      end
      for (int s = 0; s < 5; s++) begin
        if (cur[s] != prev[s]) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change %s cyc=%0d value=%0d, no change expected",
                     sname(s), cyc, cur[s]);
          end else begin
            ev_t e;
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.sig != s || e.val != cur[s]) begin
              errors++;
              $display("FAIL edge got %s=%0d at cyc %0d, required %s=%0d at cyc %0d",
                       sname(s), cur[s], cyc, sname(e.sig), e.val, e.cyc);
            end
          end
        end
      end
      if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        ev_t e;
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_edge %s=%0d at cyc %0d never seen (now cyc %0d)",
                 sname(e.sig), e.val, e.cyc, cyc);
      end
    end
    for (int s = 0; s < 5; s++) prev[s] = cur[s];
    if (done) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL leftover_expectations got %0d pending, required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/reset_request_controller.md
Name: reset_request_controller

Overview:
- Run-time reset sequencer for the three system reset domains (interconnect, peripheral, processor) on one slow clock.
- Arbitrates reset requests from several sources (watchdog, debug, software register, ...) and asserts the domains in order processor -> peripheral -> interconnect.
- Holds all three, waits for PLL lock, then releases them in order interconnect -> peripheral -> processor.
- Also performs the power-on release sequence after async_reset.

Parameters:
- NUM_REQ, 4, number of reset requesters; index 0 has the highest priority.
- STAGGER_CYCLES, 32, clk cycles between successive domain assert/release edges; must be >= 1.
- HOLD_CYCLES, 128, clk cycles all three domains stay asserted before the lock check; must be >= 1.
- NO_INTERCNCT, 1, width of intercnct_reset.
- NO_PERIFERAL, 1, width of periferal_reset.
- NO_PROCESSOR, 1, width of processor_reset.

Ports:
- clk  in  1  slowest-sync-clock.
- async_reset  in  1  reset, asynchronous, active-high; deassertion is already synchronised to clk by reset_sync upstream.
- pll_locked  in  1  PLL lock, synchronous to clk.
- req  in  NUM_REQ  level reset requests; four-phase handshake with ack.
- ack  out  NUM_REQ  one-hot completion acknowledge.
- busy  out  1  high in every state except IDLE.
- intercnct_reset  out  NO_INTERCNCT  active-high; all bits identical.
- periferal_reset  out  NO_PERIFERAL  active-high; all bits identical.
- processor_reset  out  NO_PROCESSOR  active-high; all bits identical.

Behaviour:
- Reset values (async_reset high):
  - state = HOLD, counter = 0.
  - All domain resets = all-ones.
  - ack = 0, busy = 1, grant_valid = 0.
- All outputs are registered; counter width is clog2(max(STAGGER_CYCLES, HOLD_CYCLES) + 1).
- States: IDLE, ASSERT_PROC, ASSERT_PERI, HOLD, WAIT_LOCK, REL_ICN, REL_PERI, ACK.
- IDLE, any req bit high:
  - Latch the lowest set index as grant; set grant_valid.
  - processor_reset <= 1; go to ASSERT_PROC with counter = 0.
- ASSERT_PROC: after STAGGER_CYCLES cycles, periferal_reset <= 1; go to ASSERT_PERI.
- ASSERT_PERI: after STAGGER_CYCLES cycles, intercnct_reset <= 1; go to HOLD.
- HOLD: after HOLD_CYCLES cycles, go to WAIT_LOCK.
- WAIT_LOCK:
  - Stay while pll_locked is 0; no timeout.
  - On pll_locked = 1: intercnct_reset <= 0; go to REL_ICN.
- REL_ICN: after STAGGER_CYCLES cycles, periferal_reset <= 0; go to REL_PERI.
- REL_PERI: after STAGGER_CYCLES cycles, processor_reset <= 0.
  - If grant_valid: ack[grant] <= 1; go to ACK.
  - Otherwise go to IDLE.
- ACK: hold ack[grant] high until req[grant] is low; then ack <= 0, clear grant_valid, go to IDLE.
- Latency, request edge E0 with pll_locked steady high:
  - periferal_reset asserts at E0+S; intercnct_reset asserts at E0+2S.
  - intercnct_reset releases at E0+2S+H+1; periferal_reset releases at E0+3S+H+1.
  - processor_reset releases, and ack rises, at E0+4S+H+1.
  - S = STAGGER_CYCLES, H = HOLD_CYCLES.
- Requests raised while busy are not lost: they stay pending (level) and are arbitrated on entry to IDLE. There is no preemption, including by higher-priority requesters.
- Simultaneous requests: lowest index wins; the others are served in subsequent sequences.
- pll_locked falling in REL_ICN, REL_PERI or IDLE:
  - Next edge: all resets = 1; state = HOLD with counter = 0.
  - grant and grant_valid are retained, so a pending requester is still acked after recovery.
- pll_locked falling in ACK: handled the same way, but ack drops while the sequence reruns.
- async_reset mid-sequence: immediate return to reset values. The grant is discarded and no ack is issued.
- The ordering invariant holds in every state and must be asserted by the bench:
  - processor_reset is 0 only if periferal_reset and intercnct_reset are 0.
  - periferal_reset is 0 only if intercnct_reset is 0.

Optional Feature:
- Macro RST_CAUSE_LOG_EN.
- Defined: adds outputs last_cause [clog2(NUM_REQ)] and reset_count [8].
  - last_cause is loaded with grant on IDLE exit.
  - reset_count increments on each IDLE exit and saturates at 255.
  - Both are 0 under async_reset.
  - The power-on sequence does not change either.
- Undefined: neither port nor any related register exists; the rest of the behaviour is identical.

Decomposition:
- Package rst_seq_pkg holds:
  - state enum rst_seq_state_t (logic [2:0]);
  - a count-width helper function;
  - default STAGGER/HOLD constants.
- One sub-module, prio_arb: combinational fixed-priority encoder over req. Outputs are a valid flag and a binary index; the index is registered in the parent.

Test Plan (STAGGER_CYCLES=4, HOLD_CYCLES=8, NUM_REQ=4):
- Power-on: async_reset high 3 cycles, pll_locked=1 -> resets release at cycles 9/13/17 after async_reset deasserts; ack stays 0; busy goes low.
- Single req[2] at edge E0 -> processor_reset at E0, periferal_reset at E0+4, intercnct_reset at E0+8; releases at E0+17/E0+21/E0+25; ack[2] at E0+25, held until req[2] drops, then busy=0.
- req[3] and req[1] raised in the same cycle -> req[1] served first; req[3] starts the cycle after ack[1] completes; exactly two full sequences.
- pll_locked low during HOLD for 20 cycles -> controller stays in WAIT_LOCK; intercnct_reset releases 1 edge after lock returns.
- pll_locked drops during REL_PERI -> all resets reassert next edge, HOLD restarts, and ack is still delivered to the original requester.
- async_reset pulsed mid-ASSERT_PERI -> all resets 1 immediately, no ack, power-on sequence rerun; with RST_CAUSE_LOG_EN, reset_count = 0 afterwards.
